rv32_muldiv_unit: RTL and testbench

RV32_MULDIV_UNIT -- requirements
Module: rv32_muldiv_unit

---
 rtl/rv32_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_rv32_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, followed by a sign-fix cycle and a one-cycle writeback pulse.
module rv32_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_sel,
  output logic        busy,
  output logic        done,
  output logic        wb_write_reg,
  output logic [4:0]  wb_sel_d1,
  output logic [31:0] wb_reg_d1
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [4:0]  rd_q, rd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  wbSel_q, wbSel_d;
  logic [31:0] wbReg_q, wbReg_d;

  logic        negA, negB, divZero, divFits;
  logic [31:0] magA, magB, result;
  logic [63:0] prodSigned;
  logic [31:0] quotSigned, remSigned;
  logic [32:0] mulSum, divShift;
  logic [31:0] divTrial;

  function automatic logic signedA(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic logic signedB(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic logic [31:0] magOf(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (cnt_q == 6'd31) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Sign handling always works from the latched raw operands, so magnitudes stay stable in CALC.
  always_comb begin
    negA       = signedA(op_q) & opA_q[31];
    negB       = signedB(op_q) & opB_q[31];
    magA       = magOf(opA_q, negA);
    magB       = magOf(opB_q, negB);
    divZero    = (opB_q == 32'd0);
    prodSigned = (negA ^ negB) ? (64'd0 - prod_q) : prod_q;
    quotSigned = (negA ^ negB) ? (32'd0 - quot_q) : quot_q;
    remSigned  = negA ? (32'd0 - rem_q) : rem_q;
    mulSum     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, magA} : 33'd0);
    divShift   = {rem_q, quot_q[31]};
    divFits    = (divShift >= {1'b0, magB});
    divTrial   = divShift[31:0] - magB;
    case (op_q)
      3'b000:                 result = prodSigned[31:0];
      3'b001, 3'b010, 3'b011: result = prodSigned[63:32];
      3'b100, 3'b101:         result = divZero ? 32'hFFFF_FFFF : quotSigned;
      default:                result = divZero ? opA_q : remSigned;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    wbSel_d = wbSel_q;
    wbReg_d = wbReg_q;
    if (state_q == IDLE && state_d == CALC) begin
      op_d   = funct3;
      opA_d  = rs1_val;
      opB_d  = rs2_val;
      rd_d   = rd_sel;
      cnt_d  = 6'd0;
      prod_d = {32'd0, magOf(rs2_val, signedB(funct3) & rs2_val[31])};
      quot_d = magOf(rs1_val, signedA(funct3) & rs1_val[31]);
      rem_d  = 32'd0;
    end else if (state_q == CALC) begin
      // Both datapaths step every cycle; FIX picks whichever the latched op wants.
      cnt_d  = cnt_q + 6'd1;
      prod_d = {mulSum, prod_q[31:1]};
      if (divFits) begin
        rem_d  = divTrial;
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = divShift[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
    end
    if (state_q == FIX && state_d == DONE) begin
      wbSel_d = rd_q;
      wbReg_d = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 3'd0;
      opA_q   <= 32'd0;
      opB_q   <= 32'd0;
      rd_q    <= 5'd0;
      cnt_q   <= 6'd0;
      prod_q  <= 64'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      wbSel_q <= 5'd0;
      wbReg_q <= 32'd0;
    end else begin
      op_q    <= op_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      wbSel_q <= wbSel_d;
      wbReg_q <= wbReg_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign wb_write_reg = (state_q == DONE) && (rd_q != 5'd0);
  assign wb_sel_d1    = wbSel_q;
  assign wb_reg_d1    = wbReg_q;

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Directed-vector bench for rv32_muldiv_unit: fixed-latency results, special cases,
// kill/reset abort behaviour and start-while-busy rejection.
module tb_rv32_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_sel;
  logic        busy, done, wb_write_reg;
  logic [4:0]  wb_sel_d1;
  logic [31:0] wb_reg_d1;

  int total = 0;
  int bad   = 0;

  rv32_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_sel(rd_sel), .busy(busy),
    .done(done), .wb_write_reg(wb_write_reg), .wb_sel_d1(wb_sel_d1), .wb_reg_d1(wb_reg_d1)
  );

  always #5 clk = ~clk;

  // Every comparison of the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request at edge E and scrambles the inputs right afterwards.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    rd_sel  = rd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    funct3  = 3'($urandom_range(0, 7));
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_sel  = 5'($urandom_range(0, 31));
  endtask

  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expRes,
                       input int pulseAt);
    int doneCount;
    doneCount = 0;
    applyStimulus(f, a, b, rd);
    for (int i = 1; i <= 32; i++) begin
      if (i == pulseAt) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) doneCount++;
    end
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    if (done) doneCount++;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_res"}, wb_reg_d1, expRes);
    checkOutput({tag, "_we"}, 32'(wb_write_reg), 32'(rd != 5'd0));
    checkOutput({tag, "_sel"}, 32'(wb_sel_d1), 32'(rd));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ndone"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "_hold"}, wb_reg_d1, expRes);
  endtask

  initial begin
    int doneCount;
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd_sel = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(wb_write_reg), 32'd0);
    checkOutput("rst_sel", 32'(wb_sel_d1), 32'd0);
    checkOutput("rst_reg", wb_reg_d1, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    runOp("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
    runOp("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 0);
    runOp("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 0);
    runOp("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 0);
    runOp("div0",    3'b100, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 0);
    runOp("remu0",   3'b111, 32'd5,          32'd0,         5'd10, 32'd5,         0);
    runOp("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
    runOp("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         0);
    runOp("divneg",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFD, 0);
    runOp("remneg",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFF, 0);
    runOp("divu",    3'b101, 32'd100,        32'd7,         5'd15, 32'd14,        0);
    runOp("remu",    3'b111, 32'd100,        32'd7,         5'd16, 32'd2,         0);
    runOp("rd0",     3'b000, 32'd6,          32'd9,         5'd0,  32'd54,        0);
    runOp("busystart", 3'b101, 32'd50,       32'd8,         5'd17, 32'd6,         5);

    // Kill at E+10, then a fresh start at E+20 must complete normally.
    doneCount = 0;
    applyStimulus(3'b000, 32'd3, 32'd4, 5'd18);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_busy", 32'(busy), 32'd0);
    for (int i = 11; i <= 19; i++) begin
      @(posedge clk);
      #1;
      if (done || wb_write_reg) doneCount++;
    end
    checkOutput("kill_ndone", 32'(doneCount), 32'd0);
    checkOutput("kill_reg", wb_reg_d1, 32'd6);
    runOp("afterkill", 3'b000, 32'd3, 32'd4, 5'd18, 32'd12, 0);

    // kill together with start in IDLE stays idle.
    funct3 = 3'b000; rs1_val = 32'd1; rs2_val = 32'd1; rd_sel = 5'd1;
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    checkOutput("killstart_busy", 32'(busy), 32'd0);

    // Reset at E+15 abandons the operation.
    doneCount = 0;
    applyStimulus(3'b101, 32'd77, 32'd7, 5'd19);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_we", 32'(wb_write_reg), 32'd0);
    checkOutput("midrst_sel", 32'(wb_sel_d1), 32'd0);
    checkOutput("midrst_reg", wb_reg_d1, 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done || wb_write_reg) doneCount++;
    end
    checkOutput("midrst_ndone", 32'(doneCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
